i2s_tx_stereo: RTL and testbench
================================

Name: i2s_tx_stereo

Overview:
Parametrised stereo I2S / left-justified serial transmitter for the speaker amplifier path. Accepts left/right sample pairs on a valid/ready interface and buffers them in an internal FIFO. Generates bclk, lr_clk and dout from the system clock with a runtime-programmable bclk rate. Handles start, stop and underrun cleanly at frame boundaries.

Parameters:
D_WIDTH, 16, sample width per channel (bits)
SLOT_WIDTH, 32, bclk periods per channel slot; must be >= D_WIDTH
FIFO_DEPTH, 4, sample-pair entries; power of two, >= 2
DIV_WIDTH, 8, width of bclk_half

Ports:
clk  in  1  system clock (~100 MHz)
rst_n  in  1  synchronous active-low reset
en  in  1  transmitter enable
mode  in  1  0 = I2S (MSB one bclk after lr_clk edge), 1 = left-justified
bclk_half  in  DIV_WIDTH  bclk half period in clk cycles; values 0/1 treated as 2
in_vld  in  1  sample-pair valid
in_rdy  out  1  FIFO not full
in_left  in  D_WIDTH  left sample, two's complement
in_right  in  D_WIDTH  right sample
bclk  out  1  serial bit clock
lr_clk  out  1  word select; 0 = left, 1 = right
dout  out  1  serial data, MSB first
underrun  out  1  one-clk pulse when a frame starts with the FIFO empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge clk): FIFO emptied; state IDLE; bclk=0, lr_clk=0, dout=0, underrun=0, in_rdy=1, fifo_cnt=0. Reset mid-frame aborts the frame immediately; no flush.
- FIFO: a pair is written when in_vld & in_rdy. in_rdy = (fifo_cnt < FIFO_DEPTH), registered-count based. No bypass path; write while full is ignored. Simultaneous push and pop keeps fifo_cnt constant.
- States: IDLE -> RUN when en=1 and fifo_cnt>0. RUN -> IDLE at the end of the last bit period of a frame (n=2S-1) if en=0 at that point. Otherwise RUN continues. en=0 mid-frame completes the current frame. In IDLE, bclk, lr_clk and dout are held at 0.
- Timing: bclk_half and mode are latched at each frame start (n=0); changes mid-frame are ignored. A divider counter ccnt runs 0..H-1 and toggles bclk when ccnt=H-1. The first clk of RUN is a falling-edge point with bclk=0. Bit periods are numbered n=0..2S-1 per frame (S=SLOT_WIDTH). lr_clk and dout update only at falling-edge points (bclk 1->0, or RUN entry).
- Frame start (n=0): pop one pair into the L/R hold registers. If the FIFO is empty, load zeros and pulse underrun for 1 clk.
- mode=0 (I2S): lr_clk=1 for n in [S-1, 2S-2], else 0. dout at n in [1, D] = L[D-n]; at n in [S+1, S+D] = R[S+D-n]; otherwise 0. Exception: when S=D, n=0 outputs the previous frame's R[0], taken before the hold registers reload (R=0 on the first frame).
- mode=1 (left-justified): lr_clk=1 for n in [S, 2S-1]. dout at n in [0, D-1] = L[D-1-n]; at n in [S, S+D-1] = R[S+D-1-n]; otherwise 0.
- Frame length is exactly 2*S*2*H clk cycles, with no gaps between consecutive frames.

Decomposition:
- Package i2s_pkg: tx_mode_e (MODE_I2S=0, MODE_LJ=1), tx_state_e (IDLE, RUN), and a BCLK_HALF_MIN=2 constant.
- Sub-module i2s_pair_fifo: synchronous-reset valid/ready FIFO, 2*D_WIDTH wide, FIFO_DEPTH deep, with a count output.
- The top level holds the divider, bit counter, FSM and output mux.

Test Plan:
- D=16, S=16, bclk_half=4, mode=0: push L=16'hA5C3, R=16'h0F0F, en=1 -> lr_clk rises at falling edge n=15. dout n=1..16 = A5C3 MSB first, n=17..31,0 = 0F0F. Each bit lasts 8 clk; frame = 256 clk.
- D=16, S=32, mode=1: push L=16'h8001, R=16'hFFFF -> dout n=0..15 = 8001, n=16..31 = 0, n=32..47 = FFFF, n=48..63 = 0. lr_clk high for n=32..63.
- Underrun: push 1 pair, en held 1 -> frame 2 outputs all zeros, underrun pulses once at frame-2 start, and bclk continues uninterrupted.
- FIFO full: push 4 pairs while IDLE with en=0 -> in_rdy=0, fifo_cnt=4; a 5th push is dropped. Set en=1 -> the 4 frames are output in order, with in_rdy=1 after the first pop.
- Stop and rate change: drop en mid-frame -> the frame completes, then bclk/lr_clk/dout = 0 and IDLE. Change bclk_half 4->2 mid-frame -> the period changes only at the next frame start.
- Reset mid-frame: rst_n=0 for 1 clk at n=10 -> next clk all outputs 0, fifo_cnt=0, IDLE.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the stereo I2S / left-justified transmitter.
package i2s_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } tx_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  localparam int unsigned BCLK_HALF_MIN = 2;

endpackage

// File: rtl/i2s_pair_fifo.sv
// Sample-pair FIFO with valid/ready write side, unconditional pop and occupancy count.
module i2s_pair_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     rdy_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && rdy_q;
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign rdata_c = mem_q[rd_q];
  assign rdy_o   = rdy_q;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Ready tracks the next count so it is a plain flop on the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial transmitter with programmable bclk divider.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode,
  input  logic [DIV_WIDTH-1:0]          bclk_half,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [D_WIDTH-1:0]            in_left,
  input  logic [D_WIDTH-1:0]            in_right,
  output logic                          bclk,
  output logic                          lr_clk,
  output logic                          dout,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned N_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [N_W-1:0] N_LAST = N_W'(2 * SLOT_WIDTH - 1);

  tx_state_e            state_q, state_d;
  tx_mode_e             mode_q, mode_d;
  logic [DIV_WIDTH-1:0] ccnt_q, ccnt_d, h_q, h_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [D_WIDTH-1:0]   l_q, l_d, r_q, r_d;
  logic                 bclk_q, bclk_d, lr_q, lr_d, dout_q, dout_d, underrun_q, underrun_d;
  logic                 pop_c, start_c, adv_c;
  logic [2*D_WIDTH-1:0] fifo_rdata_c;

  i2s_pair_fifo #(
    .WIDTH (2 * D_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_vld),
    .wdata_i ({in_left, in_right}),
    .pop_i   (pop_c),
    .rdata_c (fifo_rdata_c),
    .rdy_o   (in_rdy),
    .cnt_o   (fifo_cnt)
  );

  // Word-select and data bit for bit period n of a frame, as {lr, dout}.
  function automatic logic [1:0] slot_bit(tx_mode_e md, logic [N_W-1:0] n,
                                          logic [D_WIDTH-1:0] l, logic [D_WIDTH-1:0] r);
    int unsigned        ni;
    logic [D_WIDTH-1:0] sh;
    logic               ws;
    ni = 32'(n);
    sh = '0;
    if (md == MODE_I2S) begin
      ws = (ni >= SLOT_WIDTH - 1) && (ni <= 2 * SLOT_WIDTH - 2);
      if (ni >= 1 && ni <= D_WIDTH) begin
        sh = l >> (D_WIDTH - ni);
      end else if (ni >= SLOT_WIDTH + 1 && ni <= SLOT_WIDTH + D_WIDTH) begin
        sh = r >> (SLOT_WIDTH + D_WIDTH - ni);
      end
    end else begin
      ws = (ni >= SLOT_WIDTH);
      if (ni <= D_WIDTH - 1) begin
        sh = l >> (D_WIDTH - 1 - ni);
      end else if (ni >= SLOT_WIDTH && ni <= SLOT_WIDTH + D_WIDTH - 1) begin
        sh = r >> (SLOT_WIDTH + D_WIDTH - 1 - ni);
      end
    end
    return {ws, sh[0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ccnt_d     = ccnt_q;
    h_d        = h_q;
    n_d        = n_q;
    l_d        = l_q;
    r_d        = r_q;
    bclk_d     = bclk_q;
    lr_d       = lr_q;
    dout_d     = dout_q;
    underrun_d = 1'b0;
    pop_c      = 1'b0;
    start_c    = 1'b0;
    adv_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        bclk_d = 1'b0;
        lr_d   = 1'b0;
        dout_d = 1'b0;
        ccnt_d = '0;
        n_d    = '0;
        if (en && fifo_cnt != '0) begin
          state_d = RUN;
          start_c = 1'b1;
        end
      end
      RUN: begin
        if (ccnt_q == h_q - DIV_WIDTH'(1)) begin
          ccnt_d = '0;
          bclk_d = ~bclk_q;
          // Falling edge closes bit period n_q.
          if (bclk_q) begin
            if (n_q != N_LAST) begin
              n_d   = n_q + N_W'(1);
              adv_c = 1'b1;
            end else if (en) begin
              start_c = 1'b1;
            end else begin
              state_d = IDLE;
              bclk_d  = 1'b0;
              lr_d    = 1'b0;
              dout_d  = 1'b0;
              n_d     = '0;
            end
          end
        end else begin
          ccnt_d = ccnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: latch rate/mode, reload hold registers, drive bit 0.
    if (start_c) begin
      n_d    = '0;
      ccnt_d = '0;
      bclk_d = 1'b0;
      mode_d = tx_mode_e'(mode);
      h_d    = (bclk_half < DIV_WIDTH'(BCLK_HALF_MIN)) ? DIV_WIDTH'(BCLK_HALF_MIN) : bclk_half;
      if (fifo_cnt != '0) begin
        pop_c      = 1'b1;
        {l_d, r_d} = fifo_rdata_c;
      end else begin
        l_d        = '0;
        r_d        = '0;
        underrun_d = 1'b1;
      end
      {lr_d, dout_d} = slot_bit(tx_mode_e'(mode), '0, l_d, r_d);
      if (tx_mode_e'(mode) == MODE_I2S && SLOT_WIDTH == D_WIDTH) dout_d = r_q[0];
    end

    if (adv_c) begin
      {lr_d, dout_d} = slot_bit(mode_q, n_d, l_q, r_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_I2S;
      ccnt_q     <= '0;
      h_q        <= DIV_WIDTH'(BCLK_HALF_MIN);
      n_q        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      bclk_q     <= 1'b0;
      lr_q       <= 1'b0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ccnt_q     <= ccnt_d;
      h_q        <= h_d;
      n_q        <= n_d;
      l_q        <= l_d;
      r_q        <= r_d;
      bclk_q     <= bclk_d;
      lr_q       <= lr_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk     = bclk_q;
  assign lr_clk   = lr_q;
  assign dout     = dout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Randomized bench for i2s_tx_stereo against a frame-level reference model.
module tb_i2s_tx_stereo;

  localparam int D     = 16;
  localparam int S     = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NB    = $clog2(2 * S);

  logic          clk = 1'b0;
  logic          rst_n, en, mode, in_vld;
  logic [DW-1:0] bclk_half;
  logic [D-1:0]  in_left, in_right;
  logic          in_rdy, bclk, lr_clk, dout, underrun;
  logic [CW-1:0] fifo_cnt;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  i2s_tx_stereo #(
    .D_WIDTH    (D),
    .SLOT_WIDTH (S),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .bclk_half (bclk_half),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_left   (in_left),
    .in_right  (in_right),
    .bclk      (bclk),
    .lr_clk    (lr_clk),
    .dout      (dout),
    .underrun  (underrun),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, each frame as a precomputed bit/word-select table.
  logic [2*D-1:0] mq[$];
  bit             m_run = 1'b0;
  int             m_k = 0;
  int             m_h = 2;
  bit             m_und = 1'b0;
  logic [D-1:0]   m_l = '0;
  logic [D-1:0]   m_r = '0;
  bit             m_bits[2*S];
  bit             m_ws[2*S];
  int             m_size;
  bit             m_start;

  function automatic void build_frame(input bit md, input bit prev_r0);
    logic [D-1:0] tl, tr;
    int base_l, base_r;
    for (int i = 0; i < 2 * S; i++) begin
      m_bits[NB'(i)] = 1'b0;
      if (md == 1'b0) m_ws[NB'(i)] = (i >= S - 1) && (i <= 2 * S - 2);
      else            m_ws[NB'(i)] = (i >= S);
    end
    base_l = (md == 1'b0) ? 1 : 0;
    base_r = base_l + S;
    tl = m_l;
    tr = m_r;
    for (int i = 0; i < D; i++) begin
      m_bits[NB'(base_l + i)] = tl[D-1];
      if (base_r + i < 2 * S) m_bits[NB'(base_r + i)] = tr[D-1];
      tl = tl << 1;
      tr = tr << 1;
    end
    if (md == 1'b0 && S == D) m_bits[0] = prev_r0;
  endfunction

  always @(posedge clk) begin
    m_und = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_run = 1'b0;
      m_k   = 0;
      m_l   = '0;
      m_r   = '0;
      m_h   = 2;
    end else begin
      m_size  = mq.size();
      m_start = 1'b0;
      if (!m_run) begin
        m_start = en && (m_size > 0);
      end else begin
        m_k++;
        if (m_k == 4 * S * m_h) begin
          if (en) m_start = 1'b1;
          else begin
            m_run = 1'b0;
            m_k   = 0;
          end
        end
      end
      if (m_start) begin
        bit prev_r0;
        prev_r0 = m_r[0];
        if (m_size > 0) {m_l, m_r} = mq.pop_front();
        else begin
          m_l   = '0;
          m_r   = '0;
          m_und = 1'b1;
        end
        m_h   = (int'(bclk_half) < 2) ? 2 : int'(bclk_half);
        m_k   = 0;
        m_run = 1'b1;
        build_frame(mode, prev_r0);
      end
      if (in_vld && m_size < DEPTH) mq.push_back({in_left, in_right});
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int n;
      n = m_run ? m_k / (2 * m_h) : 0;
      check("bclk",     32'(bclk),     m_run ? 32'((m_k % (2 * m_h)) >= m_h) : 32'd0);
      check("lr_clk",   32'(lr_clk),   m_run ? 32'(m_ws[NB'(n)]) : 32'd0);
      check("dout",     32'(dout),     m_run ? 32'(m_bits[NB'(n)]) : 32'd0);
      check("underrun", 32'(underrun), 32'(m_und));
      check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
      check("in_rdy",   32'(in_rdy),   32'(mq.size() < DEPTH));
    end
  end

  task automatic push_pair(input logic [D-1:0] l, input logic [D-1:0] r);
    in_left  = l;
    in_right = r;
    in_vld   = 1'b1;
    @(negedge clk);
    in_vld   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6000 && m_run; i++) @(negedge clk);
    check("idle_wait", 32'(m_run), 32'd0);
    check("idle_bclk", 32'(bclk), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; bclk_half = DW'(4);
    in_vld = 1'b0; in_left = '0; in_right = '0;
    @(negedge clk);
    chk_on = 1'b1;
    check("rst_rdy", 32'(in_rdy), 32'd1);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // I2S frame, rate change mid-frame, underrun frame, stop mid-frame.
    push_pair(16'hA5C3, 16'h0F0F);
    en = 1'b1;
    repeat (100) @(negedge clk);
    bclk_half = DW'(2);
    repeat (300) @(negedge clk);
    push_pair(16'h1234, 16'hFEDC);
    repeat (60) @(negedge clk);
    en = 1'b0;
    wait_idle();

    // Fill the FIFO while idle; the fifth pair is dropped.
    for (int i = 0; i < 5; i++) push_pair(D'($urandom), D'($urandom));
    check("full_rdy", 32'(in_rdy), 32'd0);
    check("full_cnt", 32'(fifo_cnt), 32'd4);
    mode = 1'b1;
    bclk_half = DW'(3);
    en = 1'b1;
    repeat (4 * 64 * 3 + 40) @(negedge clk);
    en = 1'b0;
    wait_idle();

    // Randomized traffic, en/mode/rate churn, varied push pressure.
    for (int seg = 0; seg < 3; seg++) begin
      int odds;
      odds = (seg == 0) ? 4 : (seg == 1) ? 60 : 300;
      for (int c = 0; c < 4000; c++) begin
        in_vld   = ($urandom_range(odds - 1, 0) == 0);
        in_left  = D'($urandom);
        in_right = D'($urandom);
        if ($urandom_range(399, 0) == 0) en = ~en;
        if ($urandom_range(299, 0) == 0) mode = ~mode;
        if ($urandom_range(199, 0) == 0) bclk_half = DW'($urandom_range(5, 0));
        @(negedge clk);
      end
      in_vld = 1'b0;
    end

    // Reset in the middle of bit period 10.
    en = 1'b0;
    wait_idle();
    mode = 1'b0;
    bclk_half = DW'(4);
    push_pair(16'hC001, 16'h7FFE);
    push_pair(16'h0001, 16'h8000);
    en = 1'b1;
    for (int i = 0; i < 3000 && !(m_run && m_k / (2 * m_h) == 10); i++) @(negedge clk);
    check("n10_reached", 32'(m_run && m_k / (2 * m_h) == 10), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    check("abort_bclk", 32'(bclk), 32'd0);
    check("abort_lr",   32'(lr_clk), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_cnt",  32'(fifo_cnt), 32'd0);
    check("abort_rdy",  32'(in_rdy), 32'd1);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
